// File: rtl/led_bank_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : led_bank_ctrl_if
// Description : CPU IO-space bus bundle for the LED bank controller.
//               master = IO decoder / CPU side, slave = led_bank_ctrl.
// Ports       : LEDCtrl     decoder select for the LED block
//               ioWrite     write strobe (qualified by LEDCtrl)
//               ioRead      read strobe  (qualified by LEDCtrl)
//               write_data  16-bit write data
//               ledAddr     register select, ADDR_W bits
//               read_data   16-bit combinational read-back
//               leds        8*NUM_BYTES registered LED drive
// Revision    : 1.0 - initial release
// ============================================================================
interface led_bank_ctrl_if #(
  parameter int NUM_BYTES = 3,
  parameter int ADDR_W    = 3
);
  logic                   LEDCtrl;
  logic                   ioWrite;
  logic                   ioRead;
  logic [15:0]            write_data;
  logic [ADDR_W-1:0]      ledAddr;
  logic [15:0]            read_data;
  logic [8*NUM_BYTES-1:0] leds;

  modport master (
    output LEDCtrl, ioWrite, ioRead, write_data, ledAddr,
    input  read_data, leds
  );

  modport slave (
    input  LEDCtrl, ioWrite, ioRead, write_data, ledAddr,
    output read_data, leds
  );
endinterface
`default_nettype wire

// File: rtl/led_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : led_bank_ctrl
// Description : Memory-mapped LED output bank. NUM_BYTES byte lanes of LED
//               data plus MODE and PERIOD registers and a tick generator, so
//               the LEDs can be static, blink or rotate without CPU polling.
//               Map: 0..NUM_BYTES-1 DATA lanes, NUM_BYTES MODE,
//               NUM_BYTES+1 PERIOD, anything else reads 0 / ignores writes.
// Ports       : clock  system clock, all state on rising edge
//               reset  synchronous, active-high
//               bus    led_bank_ctrl_if slave (select, strobes, address,
//                      write data, read-back data, LED drive)
// Revision    : 1.0 - initial release
// ============================================================================
module led_bank_ctrl #(
  parameter int          NUM_BYTES      = 3,
  parameter int          ADDR_W         = 3,
  parameter logic [15:0] DEFAULT_PERIOD = 16'd9
) (
  input  logic         clock,
  input  logic         reset,
  led_bank_ctrl_if.slave bus
);

  localparam int                W           = 8 * NUM_BYTES;
  localparam logic [ADDR_W-1:0] MODE_ADDR   = ADDR_W'(NUM_BYTES);
  localparam logic [ADDR_W-1:0] PERIOD_ADDR = ADDR_W'(NUM_BYTES + 1);
  localparam logic [1:0]        MODE_BLINK   = 2'b01;
  localparam logic [1:0]        MODE_MARQUEE = 2'b10;

  logic [W-1:0]  data;
  logic [W-1:0]  data_next;
  logic [1:0]    mode;
  logic [15:0]   period;
  logic [15:0]   cnt;
  logic          phase;
  logic [W-1:0]  leds_out;
  logic [W-1:0]  led_drive;

  logic          wr_en;
  logic          rd_en;
  logic          lane_addr;
  logic          data_hit;
  logic          mode_hit;
  logic          period_hit;
  logic          cfg_wr;
  logic          tick;
  logic [7:0]    lane_rd;
  logic [15:0]   read_mux;

  assign wr_en      = bus.LEDCtrl & bus.ioWrite;
  assign rd_en      = bus.LEDCtrl & bus.ioRead;
  // MODE_ADDR equals NUM_BYTES, so "below MODE_ADDR" is exactly the lane range.
  assign lane_addr  = (bus.ledAddr < MODE_ADDR);
  assign data_hit   = wr_en & lane_addr;
  assign mode_hit   = wr_en & (bus.ledAddr == MODE_ADDR);
  assign period_hit = wr_en & (bus.ledAddr == PERIOD_ADDR);
  assign cfg_wr     = mode_hit | period_hit;

  // A config write restarts the timebase, so it also swallows any tick that
  // would otherwise fire on the same edge.
  assign tick = (cnt == period) & ~cfg_wr;

  // Lane write has priority over rotation; a tick coinciding with a lane
  // write is consumed without rotating any lane.
  always_comb begin
    data_next = data;
    if (data_hit) begin
      for (int k = 0; k < NUM_BYTES; k++) begin
        if (bus.ledAddr == ADDR_W'(k)) begin
          data_next[8*k +: 8] = bus.write_data[7:0];
        end
      end
    end else if (tick && (mode == MODE_MARQUEE)) begin
      data_next = {data[W-2:0], data[W-1]};
    end
  end

  // Blink blanks the LEDs in the off phase; every other mode (including
  // the reserved 11 encoding) shows the data register directly.
  always_comb begin
    led_drive = data;
    if ((mode == MODE_BLINK) && !phase) begin
      led_drive = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      data     <= '0;
      mode     <= 2'b00;
      period   <= DEFAULT_PERIOD;
      cnt      <= 16'd0;
      phase    <= 1'b1;
      leds_out <= '0;
    end else begin
      data <= data_next;
      if (mode_hit) begin
        mode <= bus.write_data[1:0];
      end
      if (period_hit) begin
        period <= bus.write_data;
      end
      if (cfg_wr || tick) begin
        cnt <= 16'd0;
      end else begin
        cnt <= cnt + 16'd1;
      end
      if (cfg_wr) begin
        phase <= 1'b1;
      end else if (tick && (mode == MODE_BLINK)) begin
        phase <= ~phase;
      end
      leds_out <= led_drive;
    end
  end

  always_comb begin
    lane_rd = 8'h00;
    for (int k = 0; k < NUM_BYTES; k++) begin
      if (bus.ledAddr == ADDR_W'(k)) begin
        lane_rd = data[8*k +: 8];
      end
    end
  end

  // Read-back reflects the registers as they are before the current edge,
  // so a simultaneous write shows the old value.
  always_comb begin
    read_mux = 16'h0000;
    if (rd_en) begin
      if (lane_addr) begin
        read_mux = {8'h00, lane_rd};
      end else if (bus.ledAddr == MODE_ADDR) begin
        read_mux = {14'b0, mode};
      end else if (bus.ledAddr == PERIOD_ADDR) begin
        read_mux = period;
      end
    end
  end

  assign bus.read_data = read_mux;
  assign bus.leds      = leds_out;

endmodule
`default_nettype wire
